wallace_tree_accumulator: RTL and testbench



---
 rtl/wallace_tree_accumulator.sv | 97 +++++++++
 tb/tb_wallace_tree_accumulator.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/wallace_tree_accumulator.sv
// Resolves the final sum/carry rows of an 8x8 Wallace tree into a product and
// accumulates N_TERMS products per job, with an optional saturating clamp.
module wallace_tree_accumulator #(
    parameter int PROD_WIDTH = 16,
    parameter int ACC_WIDTH  = 24,
    parameter int N_TERMS    = 8,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [PROD_WIDTH-1:0] sum_vec,
    input  logic [PROD_WIDTH-1:0] carry_vec,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ACC_WIDTH-1:0]  acc_out,
    output logic                  sat_flag,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {ACC_WIDTH{1'b1}};

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [ACC_WIDTH-1:0]  acc;
    logic [PROD_WIDTH-1:0] s1_prod;
    logic                  s1_valid;
    logic                  accept;
    logic [ACC_WIDTH:0]    acc_sum;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;
    assign acc_out   = acc;

    // Extra top bit exposes overflow for the saturating clamp.
    assign acc_sum = {1'b0, acc} + (ACC_WIDTH + 1)'(s1_prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (accept && cnt == LAST_CNT) state_nxt = DRAIN;
            DRAIN:   state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage 1: carry-propagate add; carry out of the top bit is dropped
    // since an 8x8 unsigned product never exceeds 0xFE01.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            cnt      <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_prod <= sum_vec + carry_vec;
                cnt     <= cnt + 1'b1;
            end else if (state == IDLE && start) begin
                cnt <= '0;
            end
        end
    end

    // Stage 2: accumulate; s1_valid is never set in IDLE, so the job-start
    // clear cannot collide with an accumulate step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            sat_flag <= 1'b0;
        end else if (state == IDLE && start) begin
            acc      <= '0;
            sat_flag <= 1'b0;
        end else if (s1_valid) begin
            if (SATURATE && acc_sum[ACC_WIDTH]) begin
                acc      <= ACC_MAX;
                sat_flag <= 1'b1;
            end else begin
                acc <= acc_sum[ACC_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_wallace_tree_accumulator.sv
// Directed bench: default 24-bit DUT plus 18-bit saturating and wrapping
// variants sharing the same stimulus.
module tb_wallace_tree_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] sum_vec, carry_vec;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready, out_valid, sat_flag;
    logic [23:0] acc_out;
    logic        in_ready_s, out_valid_s, sat_flag_s;
    logic [17:0] acc_out_s;
    logic        in_ready_w, out_valid_w, sat_flag_w;
    logic [17:0] acc_out_w;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wallace_tree_accumulator #(.PROD_WIDTH(16), .ACC_WIDTH(24), .N_TERMS(8), .SATURATE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sum_vec(sum_vec), .carry_vec(carry_vec),
        .in_valid(in_valid), .in_ready(in_ready), .acc_out(acc_out), .sat_flag(sat_flag),
        .out_valid(out_valid), .out_ready(out_ready));

    wallace_tree_accumulator #(.PROD_WIDTH(16), .ACC_WIDTH(18), .N_TERMS(8), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .sum_vec(sum_vec), .carry_vec(carry_vec),
        .in_valid(in_valid), .in_ready(in_ready_s), .acc_out(acc_out_s), .sat_flag(sat_flag_s),
        .out_valid(out_valid_s), .out_ready(out_ready));

    wallace_tree_accumulator #(.PROD_WIDTH(16), .ACC_WIDTH(18), .N_TERMS(8), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .sum_vec(sum_vec), .carry_vec(carry_vec),
        .in_valid(in_valid), .in_ready(in_ready_w), .acc_out(acc_out_w), .sat_flag(sat_flag_w),
        .out_valid(out_valid_w), .out_ready(out_ready));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs and samples settle 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_job();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic finish_job();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    // Back-to-back accepts of one repeated pair.
    task automatic feed(input logic [15:0] s, input logic [15:0] c, input int n);
        sum_vec   = s;
        carry_vec = c;
        in_valid  = 1'b1;
        for (int i = 0; i < n; i++) step();
        in_valid  = 1'b0;
        sum_vec   = 16'hFFFF;
        carry_vec = 16'hFFFF;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sum_vec = '0; carry_vec = '0;
        #2;
        chk("rst_acc", 32'(acc_out), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_sat", 32'(sat_flag), 32'h0);
        #10 rst_n = 1'b1;
        step();

        // Basic: 8 x 0x0100
        in_valid = 1'b1;
        step();
        chk("idle_in_ready", 32'(in_ready), 32'h0);
        in_valid = 1'b0;
        begin_job();
        chk("accum_in_ready", 32'(in_ready), 32'h1);
        feed(16'h00F0, 16'h0010, 8);
        chk("drain_out_valid", 32'(out_valid), 32'h0);
        chk("drain_in_ready", 32'(in_ready), 32'h0);
        step();
        chk("basic_out_valid", 32'(out_valid), 32'h1);
        chk("basic_acc", 32'(acc_out), 32'h000800);
        chk("basic_sat", 32'(sat_flag), 32'h0);
        finish_job();
        chk("basic_idle", 32'(out_valid), 32'h0);

        // Max products: 8 x 0xFE01 across all three variants
        begin_job();
        feed(16'hFE00, 16'h0001, 8);
        step();
        chk("max_acc24", 32'(acc_out), 32'h07F008);
        chk("max_sat24", 32'(sat_flag), 32'h0);
        chk("max_acc18_sat", 32'(acc_out_s), 32'h3FFFF);
        chk("max_flag18_sat", 32'(sat_flag_s), 32'h1);
        chk("max_acc18_wrap", 32'(acc_out_w), 32'h3F008);
        chk("max_flag18_wrap", 32'(sat_flag_w), 32'h0);
        finish_job();

        // Backpressure: in_valid 1,0,0,1,... with junk and start during gaps
        begin_job();
        chk("newjob_sat_clear", 32'(sat_flag_s), 32'h0);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                sum_vec = 16'hFFFF; carry_vec = 16'hFFFF; in_valid = 1'b0;
                start = (k == 3);
                step();
                start = 1'b0;
                step();
            end
            sum_vec = 16'h0100; carry_vec = 16'h0023; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
        end
        chk("bp_drain", 32'(out_valid), 32'h0);
        step();
        for (int h = 0; h < 5; h++) begin
            start = (h == 2);
            in_valid = (h == 3);
            chk("bp_hold_valid", 32'(out_valid), 32'h1);
            chk("bp_hold_acc", 32'(acc_out), 32'h000918);
            chk("bp_hold_ready", 32'(in_ready), 32'h0);
            step();
            start = 1'b0;
            in_valid = 1'b0;
        end
        chk("bp_acc18_sat", 32'(acc_out_s), 32'h00918);
        chk("bp_flag18_sat", 32'(sat_flag_s), 32'h0);
        // start coinciding with HOLD exit is ignored
        start = 1'b1;
        finish_job();
        start = 1'b0;
        chk("bp_idle_valid", 32'(out_valid), 32'h0);
        chk("bp_start_ignored", 32'(in_ready), 32'h0);
        step();
        chk("bp_still_idle", 32'(in_ready), 32'h0);

        // Reset mid-job after 4 accepts
        begin_job();
        feed(16'h0100, 16'h0000, 4);
        chk("partial_acc", 32'(acc_out), 32'h000300);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_acc", 32'(acc_out), 32'h0);
        chk("midrst_in_ready", 32'(in_ready), 32'h0);
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_sat", 32'(sat_flag), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        begin_job();
        feed(16'h0001, 16'h0000, 8);
        step();
        chk("post_rst_valid", 32'(out_valid), 32'h1);
        chk("post_rst_acc", 32'(acc_out), 32'h000008);
        finish_job();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
